vit_out_packer: RTL and testbench

Downstream stage of the (3,2,2) Viterbi decoder. Consumes the decoder's 2-bit decoded symbols (Dx qualified by oe) and packs four of them into bytes, first symbol in the MSBs. Bytes go into a small first-word-fall-through FIFO and leave on a valid/ready byte interface. A decoder sync_error discards any partial byte, and packing resumes on a clean symbol boundary.

---
 rtl/vit_out_packer.sv | 147 ++++++++++++++
 tb/tb_vit_out_packer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/vit_out_packer.sv
// vit_out_packer
//   Packs K-bit decoded Viterbi symbols into BYTE_W-bit words, first symbol
//   in the MSBs, and queues them in a first-word-fall-through FIFO that
//   drains over a valid/ready interface. A sync_error discards the partial
//   word and holds the packer in RESYNC until the decoder recovers.
//
// Ports
//   clock       system clock, rising edge
//   reset       asynchronous active-low reset
//   Dx          decoded symbol, qualified by oe
//   oe          symbol strobe
//   sync_error  decoder sync loss
//   data_out    FIFO head word (combinational)
//   data_valid  FIFO not empty
//   data_ready  downstream accepts data_out
//   sync_lost   high while in RESYNC
//   overflow    sticky: a completed word was dropped on a full FIFO
//   ovf_clr     synchronous clear of overflow (a same-cycle drop wins)
//   byte_count  words accepted into the FIFO, wrapping (PACKER_BYTECNT_EN only)
//
// Optional feature macro: PACKER_BYTECNT_EN
module vit_out_packer #(
   parameter int unsigned K          = 2,
   parameter int unsigned BYTE_W     = 8,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [K-1:0]      Dx,
   input  logic              oe,
   input  logic              sync_error,
   output logic [BYTE_W-1:0] data_out,
   output logic              data_valid,
   input  logic              data_ready,
   output logic              sync_lost,
   output logic              overflow,
   input  logic              ovf_clr
`ifdef PACKER_BYTECNT_EN
  ,output logic [15:0]       byte_count
`endif
);

   localparam int unsigned SPB = BYTE_W / K;
   localparam int unsigned CW  = (SPB > 1) ? $clog2(SPB) : 1;
   localparam int unsigned PW  = $clog2(FIFO_DEPTH);
   localparam int unsigned OW  = PW + 1;
   localparam logic [CW-1:0] LAST_SYM = CW'(SPB - 1);

   typedef enum logic {PACK, RESYNC} state_t;

   state_t              state_q;
   logic                sync_lost_q;
   logic [CW-1:0]       sym_cnt_q;
   // Only the older BYTE_W-K bits need storing; the newest symbol is Dx.
   logic [BYTE_W-K-1:0] shift_q;

   logic [BYTE_W-1:0]   mem_q [FIFO_DEPTH];
   logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
   logic [OW-1:0]       occ_q, occ_d;
   logic                ovf_q, ovf_d;

   logic [BYTE_W-1:0]   byte_d;
   logic                take, push, pop, full, accept, drop;

   always_comb begin
      byte_d = {shift_q, Dx};
      take   = (state_q == PACK) && oe && !sync_error;
      push   = take && (sym_cnt_q == LAST_SYM);
      pop    = data_valid && data_ready;
      full   = (occ_q == OW'(FIFO_DEPTH));
      // A pop in the same cycle frees the slot the push needs.
      accept = push && (!full || pop);
      drop   = push && full && !pop;
      occ_d  = occ_q + OW'(accept) - OW'(pop);
      ovf_d  = ovf_q;
      if (ovf_clr) ovf_d = 1'b0;
      if (drop)    ovf_d = 1'b1;
   end

   // Packer FSM
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= PACK;
         sync_lost_q <= 1'b0;
         sym_cnt_q   <= '0;
         shift_q     <= '0;
      end else begin
         case (state_q)
            PACK: begin
               if (sync_error) begin
                  state_q     <= RESYNC;
                  sync_lost_q <= 1'b1;
                  sym_cnt_q   <= '0;
                  shift_q     <= '0;
               end else if (oe) begin
                  shift_q   <= byte_d[BYTE_W-K-1:0];
                  sym_cnt_q <= (sym_cnt_q == LAST_SYM) ? '0 : sym_cnt_q + CW'(1);
               end
            end
            RESYNC: begin
               if (!sync_error) begin
                  state_q     <= PACK;
                  sync_lost_q <= 1'b0;
               end
            end
            default: begin
               state_q     <= PACK;
               sync_lost_q <= 1'b0;
            end
         endcase
      end
   end

   // Byte FIFO
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (accept) begin
            mem_q[wr_ptr_q] <= byte_d;
            wr_ptr_q        <= wr_ptr_q + PW'(1);
         end
         if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
         occ_q <= occ_d;
         ovf_q <= ovf_d;
      end
   end

`ifdef PACKER_BYTECNT_EN
   logic [15:0] bcnt_q;
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)      bcnt_q <= '0;
      else if (accept) bcnt_q <= bcnt_q + 16'd1;
   end
   assign byte_count = bcnt_q;
`endif

   assign data_out   = mem_q[rd_ptr_q];
   assign data_valid = (occ_q != '0);
   assign sync_lost  = sync_lost_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_vit_out_packer.sv
// tb_vit_out_packer
//   Table-driven bench for vit_out_packer at default parameters, plus
//   hand-written sequences for asynchronous reset and the optional
//   byte counter (PACKER_BYTECNT_EN).
module tb_vit_out_packer;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] Dx = '0;
   logic       oe = 1'b0, sync_error = 1'b0, data_ready = 1'b0, ovf_clr = 1'b0;
   logic [7:0] data_out;
   logic       data_valid, sync_lost, overflow;
`ifdef PACKER_BYTECNT_EN
   logic [15:0] byte_count;
`endif

   int checks = 0;
   int errors = 0;

   vit_out_packer #(.K(2), .BYTE_W(8), .FIFO_DEPTH(4)) dut (
      .clock      (clock),
      .reset      (reset),
      .Dx         (Dx),
      .oe         (oe),
      .sync_error (sync_error),
      .data_out   (data_out),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .sync_lost  (sync_lost),
      .overflow   (overflow),
      .ovf_clr    (ovf_clr)
`ifdef PACKER_BYTECNT_EN
     ,.byte_count (byte_count)
`endif
   );

   always #5 clock = ~clock;

   typedef struct {
      logic       oe, se;
      logic [1:0] dx;
      logic       rdy, clr;
      logic       ev;
      logic [7:0] ed;
      logic       esl, eovf;
   } vec_t;

   vec_t vecs[$];

   function automatic void addv(logic o, logic s, logic [1:0] d, logic r, logic c,
                                logic ev, logic [7:0] ed, logic esl, logic eovf);
      vec_t v;
      v.oe = o; v.se = s; v.dx = d; v.rdy = r; v.clr = c;
      v.ev = ev; v.ed = ed; v.esl = esl; v.eovf = eovf;
      vecs.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Drive at the falling edge, then sample 1 time unit after the rising edge.
   task automatic step(input logic o, input logic s, input logic [1:0] d,
                       input logic r, input logic c);
      @(negedge clock);
      oe = o; sync_error = s; Dx = d; data_ready = r; ovf_clr = c;
      @(posedge clock);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic r);
      for (int j = 0; j < 4; j++) step(1'b1, 1'b0, b[7-2*j -: 2], r, 1'b0);
   endtask

   initial begin
      logic [7:0] bt;

      // Basic packing: 11,00,10,01 -> C9
      addv(1,0,2'd3,1,0, 0,8'h00,0,0);
      addv(1,0,2'd0,1,0, 0,8'h00,0,0);
      addv(1,0,2'd2,1,0, 0,8'h00,0,0);
      addv(1,0,2'd1,1,0, 1,8'hC9,0,0);
      addv(0,0,2'd0,1,0, 0,8'h00,0,0);
      // Sync loss after 3 symbols; oe during RESYNC must be ignored
      addv(1,0,2'd1,1,0, 0,8'h00,0,0);
      addv(1,0,2'd2,1,0, 0,8'h00,0,0);
      addv(1,0,2'd3,1,0, 0,8'h00,0,0);
      addv(1,1,2'd0,1,0, 0,8'h00,1,0);
      addv(1,1,2'd0,1,0, 0,8'h00,1,0);
      addv(1,0,2'd3,1,0, 0,8'h00,0,0);
      addv(1,0,2'd1,1,0, 0,8'h00,0,0);
      addv(1,0,2'd1,1,0, 0,8'h00,0,0);
      addv(1,0,2'd1,1,0, 0,8'h00,0,0);
      addv(1,0,2'd1,1,0, 1,8'h55,0,0);
      addv(0,0,2'd0,1,0, 0,8'h00,0,0);
      // Back-pressure: 00,11,22,33 retained, 44 dropped; clr on the drop cycle loses
      for (int b = 0; b < 5; b++) begin
         bt = 8'(b * 8'h11);
         for (int j = 0; j < 4; j++)
            addv(1,0,bt[7-2*j -: 2],0,(b == 4 && j == 3),
                 (b > 0 || j == 3), 8'h00, 0, (b == 4 && j == 3));
      end
      addv(0,0,2'd0,1,0, 1,8'h11,0,1);
      addv(0,0,2'd0,1,0, 1,8'h22,0,1);
      addv(0,0,2'd0,1,0, 1,8'h33,0,1);
      addv(0,0,2'd0,1,0, 0,8'h00,0,1);
      addv(0,0,2'd0,0,1, 0,8'h00,0,0);
      // Full FIFO (01..04), then complete AA in the same cycle as a pop
      for (int b = 1; b <= 4; b++) begin
         bt = 8'(b);
         for (int j = 0; j < 4; j++)
            addv(1,0,bt[7-2*j -: 2],0,0, (b > 1 || j == 3), 8'h01, 0, 0);
      end
      addv(1,0,2'd2,0,0, 1,8'h01,0,0);
      addv(1,0,2'd2,0,0, 1,8'h01,0,0);
      addv(1,0,2'd2,0,0, 1,8'h01,0,0);
      addv(1,0,2'd2,1,0, 1,8'h02,0,0);
      addv(0,0,2'd0,1,0, 1,8'h03,0,0);
      addv(0,0,2'd0,1,0, 1,8'h04,0,0);
      addv(0,0,2'd0,1,0, 1,8'hAA,0,0);
      addv(0,0,2'd0,1,0, 0,8'h00,0,0);

      // Reset state
      #3;
      chk("rst data_out",   {24'd0, data_out}, 32'h00);
      chk("rst data_valid", {31'd0, data_valid}, 32'd0);
      chk("rst sync_lost",  {31'd0, sync_lost}, 32'd0);
      chk("rst overflow",   {31'd0, overflow}, 32'd0);
      @(negedge clock);
      reset = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].oe, vecs[i].se, vecs[i].dx, vecs[i].rdy, vecs[i].clr);
         chk($sformatf("v%0d data_valid", i), {31'd0, data_valid}, {31'd0, vecs[i].ev});
         if (vecs[i].ev)
            chk($sformatf("v%0d data_out", i), {24'd0, data_out}, {24'd0, vecs[i].ed});
         chk($sformatf("v%0d sync_lost", i), {31'd0, sync_lost}, {31'd0, vecs[i].esl});
         chk($sformatf("v%0d overflow", i), {31'd0, overflow}, {31'd0, vecs[i].eovf});
      end

      // Async reset mid-byte with one byte queued
      send_byte(8'h1B, 1'b0);
      step(1'b1, 1'b0, 2'd1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 2'd2, 1'b0, 1'b0);
      chk("pre-rst data_valid", {31'd0, data_valid}, 32'd1);
      chk("pre-rst data_out", {24'd0, data_out}, 32'h1B);
      @(negedge clock);
      oe = 1'b0;
      #2 reset = 1'b0;
      #1;
      chk("async data_out",   {24'd0, data_out}, 32'h00);
      chk("async data_valid", {31'd0, data_valid}, 32'd0);
      chk("async sync_lost",  {31'd0, sync_lost}, 32'd0);
      chk("async overflow",   {31'd0, overflow}, 32'd0);
      @(negedge clock);
      reset = 1'b1;
      step(1'b1, 1'b0, 2'd3, 1'b0, 1'b0);
      step(1'b1, 1'b0, 2'd2, 1'b0, 1'b0);
      chk("post-rst half valid", {31'd0, data_valid}, 32'd0);
      step(1'b1, 1'b0, 2'd1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
      chk("post-rst byte valid", {31'd0, data_valid}, 32'd1);
      chk("post-rst byte data", {24'd0, data_out}, 32'hE4);

`ifdef PACKER_BYTECNT_EN
      @(negedge clock);
      oe = 1'b0;
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      chk("bcnt reset", {16'd0, byte_count}, 32'd0);
      send_byte(8'h12, 1'b1);
      send_byte(8'h34, 1'b1);
      send_byte(8'h56, 1'b1);
      step(1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
      chk("bcnt three", {16'd0, byte_count}, 32'd3);
      for (int b = 0; b < 5; b++) send_byte(8'h77, 1'b0);
      chk("bcnt ovf set", {31'd0, overflow}, 32'd1);
      chk("bcnt drop", {16'd0, byte_count}, 32'd7);
      step(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
      chk("bcnt clr ovf", {31'd0, overflow}, 32'd0);
      chk("bcnt after clr", {16'd0, byte_count}, 32'd7);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
